// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: debounced key scanner with a per-key one-deep pending bit and a single event slot.
// Define KEY_AUTOREPEAT_EN to enable hold-to-repeat events.
module key_scan_ctrl #(
  parameter int N_KEYS       = 4,
  parameter int TICK_BITS    = 21,
  parameter int HOLD_TICKS   = 12,
  parameter int REPEAT_TICKS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] sw_low,
  output logic [N_KEYS-1:0] db,
  output logic              press_valid,
  input  logic              press_ready,
  output logic [2:0]        press_code,
  output logic              press_rpt,
  output logic              overflow
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM1 = 3'd1;
  localparam logic [2:0] ARM2 = 3'd2;
  localparam logic [2:0] HELD = 3'd3;
  localparam logic [2:0] REL1 = 3'd4;
  localparam logic [2:0] REL2 = 3'd5;

  logic [N_KEYS-1:0]      sync1, sync2, level;
  logic [TICK_BITS-1:0]   tcnt;
  logic                   tick;
  logic [N_KEYS-1:0][2:0] st, st_nx;
  logic [N_KEYS-1:0]      ev, rpt_fire;
  logic [N_KEYS-1:0]      pend, pend_rpt;
  logic                   any_pend, g_rpt, load;
  logic [2:0]             g_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      tcnt  <= '0;
    end else begin
      sync1 <= sw_low;
      sync2 <= sync1;
      tcnt  <= tcnt + 1'b1;
    end
  end

  assign level = ~sync2;
  assign tick  = (tcnt == '0);

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      st_nx[i] = st[i];
      case (st[i])
        IDLE:    if (level[i])  st_nx[i] = ARM1;
        ARM1:    if (tick)      st_nx[i] = ARM2;
        ARM2:    if (tick)      st_nx[i] = HELD;
        HELD:    if (!level[i]) st_nx[i] = REL1;
        REL1:    if (tick)      st_nx[i] = REL2;
        REL2:    if (tick)      st_nx[i] = IDLE;
        default:                st_nx[i] = IDLE;
      endcase
      db[i] = (st[i] == ARM1) || (st[i] == ARM2)
           || (st[i] == HELD);
      ev[i] = ((st[i] == IDLE) && level[i])
           || rpt_fire[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) st[i] <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [7:0] HOLD_N = 8'(HOLD_TICKS);
  localparam logic [7:0] REP_N  = 8'(REPEAT_TICKS);

  logic [N_KEYS-1:0][7:0] hcnt;
  logic [N_KEYS-1:0]      hrep, hstep, hhit;

  // hrep selects the repeat interval once the first hold period has fired
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      hstep[i]    = (st[i] == HELD) && level[i] && tick;
      hhit[i]     = (hcnt[i] + 8'd1)
                 == (hrep[i] ? REP_N : HOLD_N);
      rpt_fire[i] = hstep[i] && hhit[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      hrep <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (st[i] != HELD) begin
          hcnt[i] <= 8'd0;
          hrep[i] <= 1'b0;
        end else if (hstep[i]) begin
          hcnt[i] <= hhit[i] ? 8'd0 : hcnt[i] + 8'd1;
          hrep[i] <= hrep[i] | hhit[i];
        end
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

  always_comb begin
    any_pend = 1'b0;
    g_idx    = 3'd0;
    g_rpt    = 1'b0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) begin
        any_pend = 1'b1;
        g_idx    = 3'(i);
        g_rpt    = pend_rpt[i];
      end
    end
  end

  assign load = !press_valid || press_ready;

  // grant uses registered pend, so a new event is never granted on its set edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      pend_rpt <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (load && any_pend && g_idx == 3'(i))
          pend[i] <= 1'b0;
        if (ev[i] && !pend[i]) begin
          pend[i]     <= 1'b1;
          pend_rpt[i] <= rpt_fire[i];
        end
      end
      if (|(ev & pend)) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_valid <= 1'b0;
      press_code  <= 3'd0;
      press_rpt   <= 1'b0;
    end else if (load) begin
      press_valid <= any_pend;
      if (any_pend) begin
        press_code <= g_idx;
        press_rpt  <= g_rpt;
      end
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: randomized and directed bench for key_scan_ctrl
// against a key-level behavioural reference model.
module tb_key_scan_ctrl;

  localparam int NK = 4;
  localparam int TB = 4;
  localparam int HT = 3;
  localparam int RT = 2;
  localparam int TP = 1 << TB;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] sw_low = '1;
  logic          press_ready = 1'b0;
  logic [NK-1:0] db;
  logic          press_valid;
  logic [2:0]    press_code;
  logic          press_rpt;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int hs [NK][2];

  key_scan_ctrl #(
    .N_KEYS(NK), .TICK_BITS(TB),
    .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_low(sw_low),
    .db(db), .press_valid(press_valid),
    .press_ready(press_ready), .press_code(press_code),
    .press_rpt(press_rpt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pressed-level delay line, per-key lockout measured
  // in ticks (wt), ticks held (held), pending bits and the event slot.
  typedef struct packed {
    logic [NK-1:0]       p1, p2, down, pend, prpt;
    logic [NK-1:0][1:0]  wt;
    logic [NK-1:0][15:0] held;
    logic [31:0]         ecnt;
    logic                valid, rpt, ovf;
    logic [2:0]          code;
  } mst_t;

  mst_t m;

  function automatic mst_t step(mst_t s, logic [NK-1:0] sw, logic rdy);
    mst_t n;
    logic tk;
    logic [NK-1:0] ev, evr;
    int g;
    n = s;
    tk = (s.ecnt % TP) == 0;
    ev = '0;
    evr = '0;
    for (int i = 0; i < NK; i++) begin
      if (!s.down[i] && s.wt[i] == 2'd0) begin
        if (s.p2[i]) begin
          n.down[i] = 1'b1;
          n.wt[i] = 2'd2;
          ev[i] = 1'b1;
        end
      end else if (s.wt[i] != 2'd0) begin
        if (tk) n.wt[i] = 2'(s.wt[i] - 2'd1);
        n.held[i] = 16'd0;
      end else if (!s.p2[i]) begin
        n.down[i] = 1'b0;
        n.wt[i] = 2'd2;
      end else if (tk) begin
        n.held[i] = 16'(s.held[i] + 16'd1);
        if (AR && (int'(n.held[i]) == HT ||
            (int'(n.held[i]) > HT && (int'(n.held[i]) - HT) % RT == 0))) begin
          ev[i] = 1'b1;
          evr[i] = 1'b1;
        end
      end
    end
    g = -1;
    for (int i = NK - 1; i >= 0; i--) if (s.pend[i]) g = i;
    if (!s.valid || rdy) begin
      n.valid = (g >= 0);
      if (g >= 0) begin
        n.code = 3'(g);
        n.rpt = s.prpt[g];
        n.pend[g] = 1'b0;
      end
    end
    for (int i = 0; i < NK; i++) begin
      if (ev[i]) begin
        if (s.pend[i]) n.ovf = 1'b1;
        else begin
          n.pend[i] = 1'b1;
          n.prpt[i] = evr[i];
        end
      end
    end
    n.p2 = s.p1;
    n.p1 = ~sw;
    n.ecnt = s.ecnt + 32'd1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step(m, sw_low, press_ready);
  end

  always @(posedge clk) begin
    if (rst_n && press_valid === 1'b1 && press_ready)
      hs[press_code[1:0]][press_rpt] <= hs[press_code[1:0]][press_rpt] + 1;
  end

  logic [NK+5:0] obs, exp_v;
  assign obs   = {db, press_valid, press_code, press_rpt, overflow};
  assign exp_v = {m.down, m.valid, m.code, m.rpt, m.ovf};

  task automatic test_reset();
    rst_n = 1'b0;
    sw_low = '1;
    press_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_vals got=%h want=0", obs);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_idle got=%h want=%h", obs, exp_v);
      end
    end
  endtask

  task automatic test_debounce();
    int pre, n, h0, h1;
    pre = $urandom_range(1, 20);
    press_ready = 1'b1;
    h0 = hs[0][0];
    h1 = hs[0][1];
    for (int c = 0; c <= pre + 95; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL deb_model c=%0d got=%h want=%h", c, obs, exp_v);
      end
      n = c - pre;
      if (n >= 1 && n <= 7) begin
        checks++;
        if (db[0] !== (n >= 3) || press_valid !== (n == 4)) begin
          errors++;
          $display("FAIL deb_latency n=%0d db0=%b valid=%b want %b %b",
                   n, db[0], press_valid, n >= 3, n == 4);
        end
        if (n == 4) begin
          checks++;
          if (press_code !== 3'd0 || press_rpt !== 1'b0) begin
            errors++;
            $display("FAIL deb_event code=%0d rpt=%b want 0 0", press_code, press_rpt);
          end
        end
      end
      if (n == 0) sw_low[0] = 1'b0;
      else if (n >= 1 && n <= 6) sw_low[0] = 1'($urandom);
      else if (n == 7) sw_low[0] = 1'b0;
      else if (n == 13) sw_low[0] = 1'b1;
    end
    checks++;
    if (hs[0][0] - h0 != 1 || hs[0][1] != h1) begin
      errors++;
      $display("FAIL deb_count events=%0d rpt=%0d want 1 0", hs[0][0] - h0, hs[0][1] - h1);
    end
  endtask

  task automatic test_simul();
    int pre, n;
    pre = $urandom_range(1, 20);
    press_ready = 1'b1;
    for (int c = 0; c <= pre + 90; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL sim_model c=%0d got=%h want=%h", c, obs, exp_v);
      end
      n = c - pre;
      if (n == 4 || n == 5) begin
        checks++;
        if (press_valid !== 1'b1 || press_code !== 3'(n - 3)) begin
          errors++;
          $display("FAIL sim_order n=%0d valid=%b code=%0d want 1 %0d",
                   n, press_valid, press_code, n - 3);
        end
      end
      if (n == 6) begin
        checks++;
        if (press_valid !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL sim_after valid=%b ovf=%b want 0 0", press_valid, overflow);
        end
      end
      if (n == 0) sw_low[2:1] = 2'b00;
      else if (n == 12) sw_low[2:1] = 2'b11;
    end
  endtask

  task automatic test_overflow();
    int h0, p;
    press_ready = 1'b0;
    h0 = hs[3][0];
    for (int c = 0; c < 3 * 90; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ovf_model c=%0d got=%h want=%h", c, obs, exp_v);
      end
      if (c == 150) begin
        checks++;
        if (overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_early got=%b want 0", overflow);
        end
      end
      if (c == 185) begin
        checks++;
        if ({press_valid, press_code, overflow} !== 5'b1_011_1) begin
          errors++;
          $display("FAIL ovf_slot valid=%b code=%0d ovf=%b want 1 3 1",
                   press_valid, press_code, overflow);
        end
      end
      p = c % 90;
      if (p == 0) sw_low[3] = 1'b0;
      else if (p == 40) sw_low[3] = 1'b1;
    end
    press_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ovf_drain c=%0d got=%h want=%h", c, obs, exp_v);
      end
    end
    checks++;
    if (hs[3][0] - h0 != 2) begin
      errors++;
      $display("FAIL ovf_count events=%0d want 2", hs[3][0] - h0);
    end
  endtask

  task automatic test_reset_mid();
    press_ready = 1'b0;
    sw_low[2] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rm_model c=%0d got=%h want=%h", c, obs, exp_v);
      end
    end
    checks++;
    if ({db[2], press_valid, press_code, overflow} !== 6'b1_1_010_1) begin
      errors++;
      $display("FAIL rm_pre db2=%b valid=%b code=%0d ovf=%b want 1 1 2 1",
               db[2], press_valid, press_code, overflow);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (db !== '0 || press_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rm_async db=%b valid=%b ovf=%b want 0 0 0", db, press_valid, overflow);
    end
    @(negedge clk);
    sw_low = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rm_after c=%0d got=%h want=%h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_autorepeat();
    int ticks, rel_at, h0, h1;
    ticks = -1;
    rel_at = -1;
    press_ready = 1'b1;
    h0 = hs[0][0];
    h1 = hs[0][1];
    sw_low[0] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ar_model c=%0d got=%h want=%h", c, obs, exp_v);
      end
      if (rel_at < 0) begin
        if (ticks < 0) begin
          if (m.down[0]) ticks = 0;
        end else if (((m.ecnt - 32'd1) % TP) == 0) begin
          ticks++;
          if (ticks == 12) begin
            sw_low[0] = 1'b1;
            rel_at = c;
          end
        end
      end
      if (rel_at >= 0 && c >= rel_at + 80) break;
    end
    checks++;
    if (rel_at < 0) begin
      errors++;
      $display("FAIL ar_timeout ticks=%0d want 12", ticks);
    end
    checks++;
    if (hs[0][0] - h0 != 1 || hs[0][1] - h1 != (AR ? 4 : 0)) begin
      errors++;
      $display("FAIL ar_count init=%0d rpt=%0d want 1 %0d",
               hs[0][0] - h0, hs[0][1] - h1, AR ? 4 : 0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rnd_model c=%0d got=%h want=%h", c, obs, exp_v);
      end
      press_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 59) == 0) sw_low[i] = ~sw_low[i];
    end
    sw_low = '1;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_simul();
    test_overflow();
    test_reset_mid();
    test_autorepeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
